// File: rtl/data_packer_stage.sv
// data_packer_stage: per-chain bypass or lane-0 scalar packing into dense N-lane words.
// Optional `DATA_PACKER_TAG_EN adds a registered tag_out = {lanes_out, chainId_out}.
module data_packer_stage #(
  parameter int N = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter logic [MAX_CHAINS-1:0] INITIAL_FIRMWARE_MODE = '0,
  parameter logic [2*MAX_CHAINS-1:0] INITIAL_FIRMWARE_COND = '0
) (
  input  logic clk,
  input  logic resetn,
  input  logic tracing,
  input  logic valid_in,
  input  logic [1:0] eof_in,
  input  logic [1:0] bof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
  input  logic [7:0] configId,
  input  logic [7:0] configData,
  input  logic [N*DATA_WIDTH-1:0] vector_in,
  output logic [N*DATA_WIDTH-1:0] vector_out,
  output logic valid_out,
  output logic [$clog2(N+1)-1:0] lanes_out,
  output logic [$clog2(MAX_CHAINS)-1:0] chainId_out
`ifdef DATA_PACKER_TAG_EN
  ,
  output logic [7:0] tag_out
`endif
);
  localparam int DW = DATA_WIDTH;
  localparam int FW = $clog2(N+1);
  localparam int CW = $clog2(MAX_CHAINS);
  logic [DW-1:0] pbuf [N];
  logic [DW-1:0] nbuf [N];
  logic [FW-1:0] fill, nfill, inc, lanes;
  logic [CW-1:0] bchain, nbchain, ochain;
  logic [7:0] bcnt;
  logic [MAX_CHAINS-1:0] fw_mode;
  logic [1:0] fw_cond [MAX_CHAINS];
  logic [N*DW-1:0] word;
  logic emit, act, flush, sw;
  logic unused_bits;
  assign unused_bits = ^{bof_in, configData[7:2]};
  assign act = tracing && valid_in;
  assign inc = fill + 1'b1;
  assign sw = fill != '0 && chainId_in != bchain;
  assign flush = (fw_cond[chainId_in] == 2'd1 && eof_in[0]) || (fw_cond[chainId_in] == 2'd2 && eof_in[1]);
  // Lanes above fill are always zero (cleared on every emit), so emitted words come out pre-padded.
  always_comb begin
    nbuf = pbuf;
    nfill = fill;
    nbchain = bchain;
    emit = 1'b0;
    word = vector_in;
    lanes = FW'(N);
    ochain = chainId_in;
    if (act && !fw_mode[chainId_in]) emit = 1'b1;
    else if (act && sw) begin
      emit = 1'b1;
      for (int k = 0; k < N; k++) word[k*DW +: DW] = pbuf[k];
      lanes = fill;
      ochain = bchain;
      nbuf = '{default: '0};
      nbuf[0] = vector_in[DW-1:0];
      nfill = FW'(1);
      nbchain = chainId_in;
    end else if (act) begin
      for (int k = 0; k < N; k++) if (FW'(k) == fill) nbuf[k] = vector_in[DW-1:0];
      nbchain = fill == '0 ? chainId_in : bchain;
      nfill = inc;
      if (inc == FW'(N) || flush) begin
        emit = 1'b1;
        for (int k = 0; k < N; k++) word[k*DW +: DW] = nbuf[k];
        lanes = inc;
        nbuf = '{default: '0};
        nfill = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pbuf <= '{default: '0};
      fill <= '0;
      bchain <= '0;
      bcnt <= '0;
      fw_mode <= INITIAL_FIRMWARE_MODE;
      for (int k = 0; k < MAX_CHAINS; k++) fw_cond[k] <= INITIAL_FIRMWARE_COND[2*k +: 2];
      vector_out <= '0;
      valid_out <= 1'b0;
      lanes_out <= '0;
      chainId_out <= '0;
`ifdef DATA_PACKER_TAG_EN
      tag_out <= '0;
`endif
    end else begin
      pbuf <= nbuf;
      fill <= nfill;
      bchain <= nbchain;
      valid_out <= emit;
      if (emit) begin
        vector_out <= word;
        lanes_out <= lanes;
        chainId_out <= ochain;
`ifdef DATA_PACKER_TAG_EN
        tag_out <= {4'(lanes), 4'(ochain)};
`endif
      end
      if (configId != 8'(PERSONAL_CONFIG_ID)) bcnt <= '0;
      else if (!tracing) begin
        bcnt <= bcnt == 8'hFF ? bcnt : bcnt + 8'd1;
        for (int k = 0; k < MAX_CHAINS; k++) begin
          if (bcnt == 8'(k)) fw_mode[k] <= configData[0];
          if (bcnt == 8'(MAX_CHAINS + k)) fw_cond[k] <= configData[1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_data_packer_stage.sv
// tb_data_packer_stage: randomized scoreboard bench with a queue-based packing model.
module tb_data_packer_stage;
  localparam int N = 8, DW = 32, MC = 4;
  logic clk = 0, resetn = 0, tracing = 0, valid_in = 0;
  logic [1:0] eof_in = '0, bof_in = '0, chainId_in = '0;
  logic [7:0] configId = 8'd1, configData = '0;
  logic [N*DW-1:0] vector_in = '0, vector_out;
  logic valid_out;
  logic [3:0] lanes_out;
  logic [1:0] chainId_out;
`ifdef DATA_PACKER_TAG_EN
  logic [7:0] tag_out;
`endif
  always #5 clk = ~clk;
  data_packer_stage dut (
    .clk(clk), .resetn(resetn), .tracing(tracing), .valid_in(valid_in),
    .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chainId_in),
    .configId(configId), .configData(configData), .vector_in(vector_in),
    .vector_out(vector_out), .valid_out(valid_out), .lanes_out(lanes_out),
`ifdef DATA_PACKER_TAG_EN
    .tag_out(tag_out),
`endif
    .chainId_out(chainId_out)
  );
  typedef struct {logic [N*DW-1:0] w; int l; int c;} exp_t;
  exp_t sbq[$];
  exp_t e;
  int checks = 0, fails = 0;
  logic [DW-1:0] mbuf[$];
  int mchain = 0, mcnt = 0;
  int mmode[MC];
  int mcond[MC];
  task automatic push_exp(input logic [N*DW-1:0] w, input int l, input int c);
    exp_t x;
    x.w = w; x.l = l; x.c = c;
    sbq.push_back(x);
  endtask
  function automatic logic [N*DW-1:0] buf_word();
    logic [N*DW-1:0] w = '0;
    for (int i = 0; i < mbuf.size(); i++) w[i*DW +: DW] = mbuf[i];
    return w;
  endfunction
  task automatic model_data(input int ch, input logic [1:0] eof, input logic [N*DW-1:0] vec);
    bit fl;
    if (mmode[ch] == 0) begin push_exp(vec, N, ch); return; end
    if (mbuf.size() > 0 && ch != mchain) begin
      push_exp(buf_word(), mbuf.size(), mchain);
      mbuf.delete();
      mbuf.push_back(vec[DW-1:0]);
      mchain = ch;
      return;
    end
    if (mbuf.size() == 0) mchain = ch;
    mbuf.push_back(vec[DW-1:0]);
    fl = (mcond[ch] == 1 && eof[0]) || (mcond[ch] == 2 && eof[1]);
    if (mbuf.size() == N || fl) begin
      push_exp(buf_word(), mbuf.size(), ch);
      mbuf.delete();
    end
  endtask
  task automatic cyc(input logic tr, input logic v, input int ch, input logic [1:0] eof,
                     input logic [N*DW-1:0] vec, input logic [7:0] cid, input logic [7:0] cd);
    tracing = tr; valid_in = v; chainId_in = 2'(ch); eof_in = eof;
    vector_in = vec; configId = cid; configData = cd; bof_in = 2'($urandom);
    if (tr && v) model_data(ch, eof, vec);
    if (cid != 0) mcnt = 0;
    else if (!tr) begin
      if (mcnt < MC) mmode[mcnt] = int'(cd[0]);
      else if (mcnt < 2*MC) mcond[mcnt-MC] = int'(cd[1:0]);
      if (mcnt < 255) mcnt++;
    end
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    resetn = 0; valid_in = 0; tracing = 0; configId = 8'd1;
    @(posedge clk); #1;
    resetn = 1;
    mbuf.delete(); mchain = 0; mcnt = 0;
    for (int k = 0; k < MC; k++) begin mmode[k] = 0; mcond[k] = 0; end
  endtask
  task automatic configure(input logic [3:0] modes, input logic [7:0] conds);
    cyc(0, 0, 0, 0, '0, 8'd1, 0);
    for (int k = 0; k < MC; k++) cyc(0, 0, 0, 0, '0, 8'd0, {7'd0, modes[k]});
    for (int k = 0; k < MC; k++) cyc(0, 0, 0, 0, '0, 8'd0, {6'd0, conds[2*k +: 2]});
    cyc(0, 0, 0, 0, '0, 8'd0, 8'hFF);
    cyc(0, 0, 0, 0, '0, 8'd0, 8'h00);
    cyc(0, 0, 0, 0, '0, 8'd1, 0);
  endtask
  function automatic logic [N*DW-1:0] lane0(input int val);
    logic [N*DW-1:0] w = '0;
    w[DW-1:0] = DW'(val);
    return w;
  endfunction
  always @(negedge clk) if (valid_out) begin
    checks++;
    if (sbq.size() == 0) begin
      fails++;
      $display("FAIL unexpected_emit: lanes=%0d chain=%0d, required no output", lanes_out, chainId_out);
    end else begin
      e = sbq.pop_front();
      if (vector_out !== e.w || int'(lanes_out) != e.l || int'(chainId_out) != e.c) begin
        fails++;
        $display("FAIL emit: got %h lanes=%0d chain=%0d, required %h lanes=%0d chain=%0d",
                 vector_out, lanes_out, chainId_out, e.w, e.l, e.c);
      end
`ifdef DATA_PACKER_TAG_EN
      checks++;
      if (tag_out !== {4'(e.l), 4'(e.c)}) begin
        fails++;
        $display("FAIL tag_out: got %h required %h", tag_out, {4'(e.l), 4'(e.c)});
      end
`endif
    end
  end
  initial begin
    logic [N*DW-1:0] v;
    do_reset();
    checks += 4;
    if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b required 0", valid_out); end
    if (vector_out !== '0) begin fails++; $display("FAIL reset_vector: got %h required 0", vector_out); end
    if (lanes_out !== '0) begin fails++; $display("FAIL reset_lanes: got %0d required 0", lanes_out); end
    if (chainId_out !== '0) begin fails++; $display("FAIL reset_chain: got %0d required 0", chainId_out); end
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(k + 1);
    cyc(1, 1, 0, 0, v, 8'd1, 0);
    configure(4'b1110, 8'b10_01_00_00);
    for (int k = 0; k < N; k++) cyc(1, 1, 1, 0, lane0(10 + k), 8'd1, 0);
    cyc(1, 1, 2, 0, lane0(21), 8'd1, 0);
    cyc(0, 1, 2, 2'b01, lane0(99), 8'd1, 0);
    cyc(1, 1, 2, 0, lane0(22), 8'd1, 0);
    cyc(1, 1, 2, 2'b01, lane0(23), 8'd1, 0);
    cyc(1, 1, 1, 0, lane0(31), 8'd1, 0);
    cyc(1, 1, 1, 0, lane0(32), 8'd1, 0);
    cyc(1, 1, 2, 2'b01, lane0(33), 8'd1, 0);
    cyc(1, 1, 0, 0, v, 8'd1, 0);
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) configure(4'($urandom), 8'($urandom));
      for (int k = 0; k < N; k++) v[k*DW +: DW] = $urandom;
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, MC-1),
          2'($urandom), v, 8'd1, 0);
    end
    do_reset();
    configure(4'b0010, 8'h00);
    for (int k = 0; k < 5; k++) cyc(1, 1, 1, 0, lane0(40 + k), 8'd1, 0);
    do_reset();
    configure(4'b0010, 8'h00);
    for (int k = 0; k < N; k++) cyc(1, 1, 1, 0, lane0(50 + k), 8'd1, 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, '0, 8'd1, 0);
    checks++;
    if (sbq.size() != 0) begin fails++; $display("FAIL missing_emits: got %0d outstanding, required 0", sbq.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
